// File: rtl/b_skew_loader.sv
// rtl/b_skew_loader.sv - loads B rows into DIM transpose FIFOs, then streams them out with diagonally skewed shift enables
module b_skew_loader #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DEPTH*BITS-1:0] in_row,
  input  logic                  go,
  output logic [DEPTH*BITS-1:0] fifo_row,
  output logic [DIM-1:0]        fifo_wr,
  output logic [DIM-1:0]        fifo_en,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
);

  localparam int RCW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW  = (DIM + DEPTH - 1 > 1) ? $clog2(DIM + DEPTH - 1) : 1;
  localparam logic [RCW-1:0] ROW_LAST = RCW'(DIM - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'(DIM + DEPTH - 2);

  typedef enum logic [1:0] {S_LOAD, S_ARMED, S_STREAM, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [RCW-1:0] row_cnt, row_cnt_nxt;
  logic [TW-1:0]  t, t_nxt;
  logic [DIM-1:0] wr_nxt;
  logic           hs;

  // fifo_row is only a data bus: it survives clear so FIFOs never see a spurious change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      row_cnt  <= '0;
      t        <= '0;
      fifo_wr  <= '0;
      fifo_row <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      t       <= t_nxt;
      fifo_wr <= wr_nxt;
      if (hs && !clear) fifo_row <= in_row;
    end
  end

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    t_nxt       = t;
    wr_nxt      = '0;
    fifo_en     = '0;
    in_ready    = (state == S_LOAD);
    armed       = (state == S_ARMED);
    busy        = (state == S_STREAM);
    done        = (state == S_DONE);
    hs          = in_valid && in_ready;

    case (state)
      S_LOAD: begin
        if (hs) begin
          wr_nxt = DIM'(1) << row_cnt;
          if (row_cnt == ROW_LAST) begin
            state_nxt   = S_ARMED;
            row_cnt_nxt = '0;
          end else begin
            row_cnt_nxt = row_cnt + RCW'(1);
          end
        end
      end
      S_ARMED: begin
        if (go) begin
          state_nxt = S_STREAM;
          t_nxt     = '0;
        end
      end
      S_STREAM: begin
        // FIFO k shifts during the DEPTH-cycle window starting at t == k
        for (int k = 0; k < DIM; k++)
          fifo_en[k] = (t >= TW'(k)) && (t <= TW'(k + DEPTH - 1));
        if (t == T_LAST) begin
          state_nxt = S_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      S_DONE:  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase

    if (clear) begin
      state_nxt   = S_LOAD;
      row_cnt_nxt = '0;
      t_nxt       = '0;
      wr_nxt      = '0;
    end
  end

endmodule

// File: tb/tb_b_skew_loader.sv
// tb/tb_b_skew_loader.sv - randomized self-checking bench for b_skew_loader
module tb_b_skew_loader;
  localparam int DIM = 8, DEPTH = 8, BITS = 8;
  localparam int W = DEPTH * BITS;
  localparam int NT = DIM + DEPTH - 1;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, go = 1'b0;
  logic [W-1:0] in_row = '0;
  logic in_ready, armed, busy, done;
  logic [W-1:0] fifo_row;
  logic [DIM-1:0] fifo_wr, fifo_en;

  int checks = 0, errors = 0;
  logic [W-1:0] last_row = '0;

  always #5 clk = ~clk;

  b_skew_loader #(.DIM(DIM), .DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .go(go), .fifo_row(fifo_row), .fifo_wr(fifo_wr), .fifo_en(fifo_en),
    .armed(armed), .busy(busy), .done(done)
  );

  // Reference: FIFO k shifts while k <= t < k+DEPTH
  function automatic logic [DIM-1:0] en_at(input int tt);
    logic [DIM-1:0] e;
    e = '0;
    for (int k = 0; k < DIM; k++) e[k] = (tt >= k) && (tt < k + DEPTH);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < W; i += 32) r[i+:32] = $urandom;
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; go = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b1000 || fifo_wr !== '0 || fifo_en !== '0 || fifo_row !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy/arm/busy/done=%b wr=%h en=%h row=%h exp 1000 00 00 0",
               {in_ready, armed, busy, done}, fifo_wr, fifo_en, fifo_row);
    end
    #1 rst_n = 1'b1;
    last_row = '0;
    @(posedge clk); #1;
  endtask

  // mode 0: back-to-back pattern rows; 1: alternate gaps; 2: random gaps plus stray go
  task automatic test_load(input int mode);
    logic [W-1:0] rows[DIM];
    logic [DIM-1:0] exp_wr;
    logic [W-1:0] exp_row;
    int r = 0, prev = -1, cyc = 0;
    bit v;
    for (int i = 0; i < DIM; i++) begin
      if (mode == 0) for (int j = 0; j < DEPTH; j++) rows[i][j*BITS+:BITS] = BITS'(i * DEPTH + j);
      else rows[i] = rand_row();
    end
    while ((r < DIM || prev >= 0) && cyc < 100) begin
      v = (r < DIM) && ((mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0));
      in_valid = v;
      if (v) in_row = rows[r]; else in_row = rand_row();
      go = (mode == 2 && r < DIM) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      exp_wr = '0;
      exp_row = last_row;
      if (prev >= 0) begin exp_wr[prev] = 1'b1; exp_row = rows[prev]; end
      checks++;
      if (fifo_wr !== exp_wr || fifo_row !== exp_row) begin
        errors++;
        $display("FAIL load_write m%0d c%0d: got wr=%h row=%h exp wr=%h row=%h", mode, cyc, fifo_wr, fifo_row, exp_wr, exp_row);
      end
      checks++;
      if ({in_ready, armed, busy, done} !== {r < DIM, r == DIM, 2'b00} || fifo_en !== '0) begin
        errors++;
        $display("FAIL load_status m%0d c%0d: got rdy/arm/busy/done=%b en=%h exp %b%b00 en=00",
                 mode, cyc, {in_ready, armed, busy, done}, fifo_en, r < DIM, r == DIM);
      end
      last_row = exp_row;
      @(posedge clk); #1;
      prev = v ? r : -1;
      if (v) r++;
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL load_timeout m%0d: got %0d rows exp %0d", mode, r, DIM); end
    go = 1'b0; in_valid = 1'b1; in_row = rand_row();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({in_ready, armed} !== 2'b01 || fifo_wr !== '0 || fifo_row !== last_row) begin
        errors++;
        $display("FAIL armed_hold: got rdy/arm=%b wr=%h exp 01 wr=00", {in_ready, armed}, fifo_wr);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stream(input bit glitch);
    int cnt[DIM];
    foreach (cnt[k]) cnt[k] = 0;
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    for (int t = 0; t < NT; t++) begin
      if (glitch) go = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (fifo_en !== en_at(t)) begin
        errors++; $display("FAIL stream_en t%0d: got %h exp %h", t, fifo_en, en_at(t));
      end
      checks++;
      if ({in_ready, armed, busy, done} !== 4'b0010 || fifo_wr !== '0) begin
        errors++; $display("FAIL stream_status t%0d: got %b wr=%h exp 0010 wr=00", t, {in_ready, armed, busy, done}, fifo_wr);
      end
      for (int k = 0; k < DIM; k++) cnt[k] += int'(fifo_en[k]);
      @(posedge clk); #1;
    end
    go = glitch;
    @(negedge clk);
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b0001 || fifo_en !== '0) begin
      errors++; $display("FAIL done_pulse: got %b en=%h exp 0001 en=00", {in_ready, armed, busy, done}, fifo_en);
    end
    @(posedge clk); #1; go = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b1000) begin
      errors++; $display("FAIL after_done: got %b exp 1000", {in_ready, armed, busy, done});
    end
    for (int k = 0; k < DIM; k++) begin
      checks++;
      if (cnt[k] != DEPTH) begin errors++; $display("FAIL shift_count k%0d: got %0d exp %0d", k, cnt[k], DEPTH); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      checks++;
      if (fifo_en !== en_at(t)) begin errors++; $display("FAIL clear_pre_en t%0d: got %h exp %h", t, fifo_en, en_at(t)); end
      if (t == 4) clear = 1'b1;
      @(posedge clk); #1;
    end
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b1000 || fifo_en !== '0 || fifo_wr !== '0 || fifo_row !== last_row) begin
      errors++;
      $display("FAIL clear_state: got %b en=%h wr=%h row=%h exp 1000 en=00 wr=00 row=%h",
               {in_ready, armed, busy, done}, fifo_en, fifo_wr, fifo_row, last_row);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_no_done c%0d: got done=%b busy=%b exp 0 0", c, done, busy); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    go = 1'b1; @(posedge clk); #1; go = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      @(negedge clk);
      checks++;
      if (fifo_en !== en_at(t)) begin errors++; $display("FAIL areset_pre_en t%0d: got %h exp %h", t, fifo_en, en_at(t)); end
      if (t < 10) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b1000 || fifo_en !== '0 || fifo_wr !== '0 || fifo_row !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got %b en=%h wr=%h row=%h exp 1000 zeros", {in_ready, armed, busy, done}, fifo_en, fifo_wr, fifo_row);
    end
    @(negedge clk); rst_n = 1'b1; last_row = '0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({in_ready, armed, busy, done} !== 4'b1000 || fifo_en !== '0) begin
      errors++; $display("FAIL areset_release: got %b en=%h exp 1000 en=00", {in_ready, armed, busy, done}, fifo_en);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_load(0);
    test_stream(1'b0);
    test_load(1);
    test_stream(1'b1);
    test_load(2);
    test_clear;
    test_load(2);
    test_async_reset;
    test_load(0);
    test_stream(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/b_skew_loader.md
Name: b_skew_loader

Overview:
- Upstream stage for the matrix-B transpose FIFO bank; one instance drives DIM transpose FIFOs.
- Accepts B one row at a time over a valid/ready handshake and writes row k into FIFO k with a one-hot write pulse.
- On a go command it drives diagonally skewed shift enables, so FIFO k starts shifting k cycles after FIFO 0 and feeds the systolic array with the required wavefront.
- Signals completion with a one-cycle done pulse.

Parameters:
- DIM, 8, number of transpose FIFOs fed (rows of B per tile).
- DEPTH, 8, elements per row; equals the FIFO depth.
- BITS, 8, width of one element.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns the block to LOAD.
- in_valid  input  1  in_row holds a valid row.
- in_ready  output  1  block accepts a row this cycle.
- in_row  input  DEPTH x BITS  one row of B (element i on entry i).
- go  input  1  start the stream phase; honoured only in ARMED.
- fifo_row  output  DEPTH x BITS  row data broadcast to all FIFO row inputs.
- fifo_wr  output  DIM  one-hot write strobes to the FIFOs.
- fifo_en  output  DIM  shift enables to the FIFOs.
- armed  output  1  all DIM rows loaded; waiting for go.
- busy  output  1  STREAM in progress.
- done  output  1  one-cycle pulse after the last stream cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low (rst_n); the clock port is clk.
  - Reset state: LOAD, row_cnt=0, t=0, fifo_row=0, fifo_wr=0, fifo_en=0, armed=0, busy=0, done=0.
- States: LOAD, ARMED, STREAM, DONE.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready.
  - On a handshake: registered fifo_row<=in_row and fifo_wr<=one-hot(row_cnt), both visible the next cycle for exactly one cycle (latency 1); row_cnt increments.
  - No handshake: fifo_wr<=0, fifo_row holds; gaps in in_valid are allowed.
  - On the handshake with row_cnt==DIM-1: next state ARMED, row_cnt<=0.
- ARMED:
  - in_ready=0, armed=1.
  - go=1 moves to STREAM next cycle with t=0.
  - go outside ARMED is ignored.
- STREAM:
  - busy=1, in_ready=0.
  - t counts 0 .. DIM+DEPTH-2.
  - fifo_en[k]=1 iff k <= t <= k+DEPTH-1, so each FIFO shifts exactly DEPTH times.
  - fifo_en is decoded from the registered state and t only; there is no input-to-output path.
  - After t==DIM+DEPTH-2, next state DONE.
- DONE:
  - done=1 for exactly one cycle; fifo_en=0.
  - Next state LOAD; in_ready=1 the following cycle.
- Interlock: fifo_wr and fifo_en are never asserted in the same cycle.
- clear:
  - Overrides every state, takes effect at the next edge.
  - Result matches reset values, except fifo_row holds its value.
  - No done pulse is generated for an aborted sequence.
- Asynchronous reset mid-STREAM: immediate return to reset values; the partially shifted FIFOs are not restored (the FIFOs share rst_n).
- Counters:
  - row_cnt width is clog2(DIM).
  - t width is clog2(DIM+DEPTH-1).
  - No wrap-around is reachable because every transition is taken at the explicit terminal count.

Test Plan:
- Reset then 8 back-to-back rows (row r = {r*8+7..r*8}) -> fifo_wr = 0x01,0x02,...,0x80 on cycles 1..8, each with the matching fifo_row; armed=1 from cycle 9; in_ready=0 in ARMED.
- Rows with in_valid low on alternate cycles -> still exactly 8 one-hot pulses in order; row_cnt holds across gaps; armed only after the 8th.
- go in ARMED -> STREAM lasts 15 cycles:
  - fifo_en[0] high on t=0..7, fifo_en[7] high on t=7..14, fifo_en=0xFF only at t=7.
  - done pulses on the 16th cycle; in_ready=1 the cycle after.
- go pulsed during LOAD and during STREAM -> ignored: no early stream, no restart, enable pattern unchanged.
- clear at t=4 of STREAM -> next cycle: LOAD, fifo_en=0, busy=0, no done; a fresh 8-row load works normally.
- rst_n low asynchronously at t=10 -> outputs zero before the next edge; block in LOAD with in_ready=1 after release.
